// File: rtl/bg_pixel_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  bg_pixel_fifo : background pixel FIFO. Accepts 8-pixel tile rows from the
//  fetcher, discards SCX mod 8 pixels, shifts one pixel per T-cycle to the LCD.
//  Option macro: BG_FIFO_PALETTE_EN (BGP-mapped pixel_out when defined)
//  Revision: 1.0
// ============================================================================
module bg_pixel_fifo #(
    parameter int DEPTH = 16,
    parameter int X_MAX = 160
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       tclk_in,
    input  logic                       line_start_in,
    input  logic                       window_start_in,
    input  logic [7:0]                 SCX_in,
    input  logic                       valid_pixels_in,
    input  logic [7:0][1:0]            pixels_in,
    output logic                       bg_fifo_empty_out,
    input  logic                       pop_stall_in,
    input  logic                       bg_ena_in,
    input  logic [7:0]                 BGP_in,
    output logic                       pixel_valid_out,
    output logic [1:0]                 pixel_raw_out,
    output logic [1:0]                 pixel_out,
    output logic [$clog2(X_MAX)-1:0]   X_out,
    output logic                       line_done_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int XW = $clog2(X_MAX);

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] count_q, count_d;
    logic [XW-1:0] x_q, x_d, xout_q, xout_d;
    logic [2:0]    disc_q, disc_d;
    logic          done_q, done_d, empty_q;
    logic [1:0]    raw_q, raw_d, pix_q, pix_d, raw_w, shade_w;
    logic          valid_q, valid_d, ldone_q, ldone_d;
    logic          flush_w, push_w, pop_w;
    logic          scx_unused;

    assign scx_unused = ^SCX_in[7:3];

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
        return s[PW-1:0];
    endfunction

    assign flush_w = tclk_in && (line_start_in || window_start_in);
    assign push_w  = tclk_in && valid_pixels_in && (count_q == '0) && !flush_w;
    assign pop_w   = tclk_in && (count_q != '0) && !pop_stall_in && !done_q && !push_w && !flush_w;
    assign raw_w   = bg_ena_in ? mem_q[rd_q] : 2'd0;

`ifdef BG_FIFO_PALETTE_EN
    assign shade_w = BGP_in[{raw_w, 1'b0} +: 2];
`else
    logic bgp_unused;
    assign bgp_unused = ^BGP_in;
    assign shade_w    = raw_w;
`endif

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        x_d     = x_q;
        done_d  = done_q;
        disc_d  = disc_q;
        raw_d   = raw_q;
        pix_d   = pix_q;
        xout_d  = xout_q;
        valid_d = 1'b0;
        // Line-done trails the final visible pixel by one clk_in.
        ldone_d = valid_q && (xout_q == XW'(X_MAX - 1));
        if (flush_w) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
            if (line_start_in) begin
                x_d    = '0;
                done_d = 1'b0;
                disc_d = SCX_in[2:0];
            end
        end else if (push_w) begin
            wr_d    = ptr_add(wr_q, 8);
            count_d = CW'(8);
        end else if (pop_w) begin
            rd_d    = ptr_add(rd_q, 1);
            count_d = count_q - 1'b1;
            if (disc_q != 3'd0) begin
                disc_d = disc_q - 3'd1;
            end else begin
                raw_d   = raw_w;
                pix_d   = shade_w;
                xout_d  = x_q;
                valid_d = 1'b1;
                if (x_q == XW'(X_MAX - 1)) done_d = 1'b1;
                else                        x_d    = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push_w) begin
            for (int i = 0; i < 8; i++) mem_q[ptr_add(wr_q, i)] <= pixels_in[i];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            x_q     <= '0;
            xout_q  <= '0;
            disc_q  <= 3'd0;
            done_q  <= 1'b1;
            empty_q <= 1'b1;
            raw_q   <= 2'd0;
            pix_q   <= 2'd0;
            valid_q <= 1'b0;
            ldone_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            x_q     <= x_d;
            xout_q  <= xout_d;
            disc_q  <= disc_d;
            done_q  <= done_d;
            empty_q <= (count_d == '0);
            raw_q   <= raw_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            ldone_q <= ldone_d;
        end
    end

    assign bg_fifo_empty_out = empty_q;
    assign pixel_valid_out   = valid_q;
    assign pixel_raw_out     = raw_q;
    assign pixel_out         = pix_q;
    assign X_out             = xout_q;
    assign line_done_out     = ldone_q;
endmodule
`default_nettype wire

// File: tb/tb_bg_pixel_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  tb_bg_pixel_fifo : scoreboard bench for bg_pixel_fifo with a queue-based
//  reference model of the background FIFO line behaviour.
//  Revision: 1.0
// ============================================================================
module tb_bg_pixel_fifo;
    localparam int DEPTH = 16;
    localparam int X_MAX = 160;
    localparam int XW    = $clog2(X_MAX);

    logic            clk_in = 1'b0, rst_in = 1'b0, tclk_in = 1'b0;
    logic            line_start_in = 1'b0, window_start_in = 1'b0;
    logic            valid_pixels_in = 1'b0, pop_stall_in = 1'b0, bg_ena_in = 1'b1;
    logic [7:0]      SCX_in = 8'd0, BGP_in = 8'hE4;
    logic [7:0][1:0] pixels_in = '0;
    logic            bg_fifo_empty_out, pixel_valid_out, line_done_out;
    logic [1:0]      pixel_raw_out, pixel_out;
    logic [XW-1:0]   X_out;

    bg_pixel_fifo #(.DEPTH(DEPTH), .X_MAX(X_MAX)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .tclk_in(tclk_in),
        .line_start_in(line_start_in), .window_start_in(window_start_in),
        .SCX_in(SCX_in), .valid_pixels_in(valid_pixels_in), .pixels_in(pixels_in),
        .bg_fifo_empty_out(bg_fifo_empty_out), .pop_stall_in(pop_stall_in),
        .bg_ena_in(bg_ena_in), .BGP_in(BGP_in), .pixel_valid_out(pixel_valid_out),
        .pixel_raw_out(pixel_raw_out), .pixel_out(pixel_out), .X_out(X_out),
        .line_done_out(line_done_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] raw;
        logic [1:0] shade;
        int         x;
        int         cyc;
    } exp_t;

    // Reference model: line state plus the FIFO contents as a plain queue.
    logic [1:0] mq[$];
    exp_t       sb[$];
    int         m_x = 0, m_disc = 0, ld_exp = 0, ld_seen = 0;
    bit         m_done = 1'b1, prev_last = 1'b0;
    int         n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit ls, input bit ws, input logic [7:0] scx,
                              input bit v, input logic [7:0][1:0] pix);
        logic [1:0] e;
        int raw, shade;
        if (ls) begin
            mq.delete();
            m_x = 0; m_done = 1'b0; m_disc = scx % 8;
        end else if (ws) begin
            mq.delete();
        end else if (v && mq.size() == 0) begin
            for (int i = 0; i < 8; i++) mq.push_back(pix[i]);
        end else if (mq.size() > 0 && !pop_stall_in && !m_done) begin
            e = mq.pop_front();
            if (m_disc > 0) begin
                m_disc--;
            end else begin
                raw = bg_ena_in ? int'(e) : 0;
`ifdef BG_FIFO_PALETTE_EN
                shade = (int'(BGP_in) >> (2 * raw)) % 4;
`else
                shade = raw;
`endif
                sb.push_back('{raw[1:0], shade[1:0], m_x, cyc + 1});
                if (m_x == X_MAX - 1) begin m_done = 1'b1; ld_exp++; end
                else m_x++;
            end
        end
    endtask

    // Issue one T-cycle (called at a negedge), then idle for gap clocks.
    task automatic tstep(input bit ls, input bit ws, input bit v, input logic [7:0] scx,
                         input logic [7:0][1:0] pix, input int gap);
        line_start_in = ls; window_start_in = ws; valid_pixels_in = v;
        SCX_in = scx; pixels_in = pix; tclk_in = 1'b1;
        model_step(ls, ws, scx, v, pix);
        @(negedge clk_in);
        tclk_in = 1'b0; line_start_in = 1'b0; window_start_in = 1'b0; valid_pixels_in = 1'b0;
        chk("empty", bg_fifo_empty_out, (mq.size() == 0) ? 1 : 0);
        repeat (gap) @(negedge clk_in);
    endtask

    function automatic logic [7:0][1:0] rand_row();
        logic [7:0][1:0] r;
        for (int i = 0; i < 8; i++) r[i] = 2'($urandom_range(3));
        return r;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_empty"}, bg_fifo_empty_out, 1);
        chk({tag, "_valid"}, pixel_valid_out, 0);
        chk({tag, "_pix"},   pixel_out, 0);
        chk({tag, "_raw"},   pixel_raw_out, 0);
        chk({tag, "_x"},     X_out, 0);
        chk({tag, "_ldone"}, line_done_out, 0);
    endtask

    // Scoreboard monitor: pops an expectation on every presented pixel.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                if (line_done_out) begin
                    ld_seen++;
                    chk("line_done_after_last", prev_last, 1);
                end
                prev_last = pixel_valid_out && (X_out == XW'(X_MAX - 1));
                if (pixel_valid_out) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pixel_valid", pixel_valid_out, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("pix_cycle", cyc, e.cyc);
                        chk("pix_raw", pixel_raw_out, e.raw);
                        chk("pix_shade", pixel_out, e.shade);
                        chk("pix_x", X_out, e.x);
                    end
                end
            end else begin
                prev_last = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0][1:0] row;
        logic [XW-1:0]   xs;
        int pushes, iters;

        repeat (3) @(negedge clk_in);
        chk_reset_outputs("reset");
        rst_in = 1'b1;
        @(negedge clk_in);

        // Done after reset: a pushed row is stored but never popped.
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (4) tstep(0, 0, 0, 8'd0, '0, 1);

        // SCX=3, pattern 0,1,2,3,0,1,2,3, BGP identity.
        for (int i = 0; i < 8; i++) row[i] = 2'(i % 4);
        BGP_in = 8'hE4;
        tstep(1, 0, 0, 8'd3, '0, 1);
        tstep(0, 0, 1, 8'd0, row, 2);
        repeat (8) tstep(0, 0, 0, 8'd0, '0, 1);

        // Valid held for two consecutive T-cycles: only one row accepted.
        tstep(1, 0, 0, 8'd0, '0, 0);
        tstep(0, 0, 1, 8'd0, rand_row(), 0);
        tstep(0, 0, 1, 8'd0, rand_row(), 0);
        repeat (9) tstep(0, 0, 0, 8'd0, '0, 0);

        // Stall with four pixels left.
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (4) tstep(0, 0, 0, 8'd0, '0, 1);
        pop_stall_in = 1'b1;
        xs = X_out;
        repeat (6) begin
            tstep(0, 0, 0, 8'd0, '0, 2);
            chk("stall_x_frozen", X_out, xs);
        end
        pop_stall_in = 1'b0;
        repeat (5) tstep(0, 0, 0, 8'd0, '0, 1);

        // Full line at SCX=0, random palette and gaps.
        BGP_in = 8'($urandom);
        pushes = 0; iters = 0;
        tstep(1, 0, 0, 8'd0, '0, 1);
        while (!m_done && iters < 1000) begin
            if (mq.size() == 0) pushes++;
            tstep(0, 0, mq.size() == 0, 8'd0, rand_row(), $urandom_range(2));
            iters++;
        end
        chk("full_line_pushes", pushes, 20);
        chk("full_line_x", X_out, X_MAX - 1);
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (4) tstep(0, 0, 0, 8'd0, '0, 1);

        // Window start with a push on empty FIFO: push dropped.
        tstep(1, 0, 0, 8'd5, '0, 1);
        tstep(0, 1, 1, 8'd0, rand_row(), 1);
        chk("win_push_dropped", bg_fifo_empty_out, 1);
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (8) tstep(0, 0, 0, 8'd0, '0, 1);
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (3) tstep(0, 0, 0, 8'd0, '0, 1);
        // Line start beats window start: discard reloaded, X back to 0.
        tstep(1, 1, 0, 8'd2, '0, 1);
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (8) tstep(0, 0, 0, 8'd0, '0, 1);

        // Randomized traffic.
        for (int n = 0; n < 500; n++) begin
            pop_stall_in = ($urandom_range(3) == 0);
            bg_ena_in    = ($urandom_range(7) != 0);
            BGP_in       = 8'($urandom);
            tstep($urandom_range(39) == 0, $urandom_range(49) == 0, $urandom_range(1) == 1,
                  8'($urandom), rand_row(), $urandom_range(2));
        end
        pop_stall_in = 1'b0; bg_ena_in = 1'b1;

        // Asynchronous reset mid-line with five pixels buffered.
        BGP_in = 8'hE4;
        for (int i = 0; i < 8; i++) row[i] = 2'd3;
        tstep(1, 0, 0, 8'd0, '0, 1);
        tstep(0, 0, 1, 8'd0, row, 1);
        repeat (3) tstep(0, 0, 0, 8'd0, '0, 1);
        chk("pre_reset_count5", mq.size(), 5);
        #2 rst_in = 1'b0;
        #1 chk_reset_outputs("async_reset");
        mq.delete(); m_x = 0; m_disc = 0; m_done = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        tstep(0, 0, 1, 8'd0, rand_row(), 1);
        repeat (3) tstep(0, 0, 0, 8'd0, '0, 1);

        repeat (3) @(negedge clk_in);
        chk("scoreboard_drained", sb.size(), 0);
        chk("line_done_count", ld_seen, ld_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
